// File: rtl/controller_packet_rx.sv
// Receive-side decoder for controller button reports carried in network_stack_rx frames.
// Validates the duplicated-byte button word, tracks frame statistics and a link-loss watchdog.
module controller_packet_rx #(
   parameter int PAYLOAD_IDX    = 12,
   parameter int MAX_WORDS      = 64,
   parameter int TIMEOUT_CYCLES = 5_000_000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        axiiv,
   input  logic [15:0] axiid,
   output logic [7:0]  buttons,
   output logic        buttons_valid,
   output logic        buttons_changed,
   output logic        timed_out,
   output logic [15:0] good_count,
   output logic [15:0] bad_count
);

   localparam int                IDX_W    = $clog2(MAX_WORDS + 2);
   localparam logic [IDX_W-1:0]  PAY_IDX  = IDX_W'(PAYLOAD_IDX);
   localparam logic [IDX_W-1:0]  MAX_IDX  = IDX_W'(MAX_WORDS);
   localparam logic [22:0]       WD_LIMIT = 23'(TIMEOUT_CYCLES);

   typedef enum logic [1:0] {SKIP, IDLE, RECV, OVERLONG} state_t;

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   word_idx_q, word_idx_d;
   logic [15:0]        payload_q, payload_d;
   logic [7:0]         buttons_q, buttons_d;
   logic               valid_q, valid_d;
   logic               changed_q, changed_d;
   logic               timed_out_q, timed_out_d;
   logic [15:0]        good_q, good_d;
   logic [15:0]        bad_q, bad_d;
   logic [22:0]        wd_q, wd_d, wd_inc;
   logic               frame_good, frame_bad;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   always_comb begin
      state_d    = state_q;
      word_idx_d = word_idx_q;
      payload_d  = payload_q;
      frame_good = 1'b0;
      frame_bad  = 1'b0;
      case (state_q)
         // Wait out any frame already in flight when reset released.
         SKIP: begin
            if (!axiiv) state_d = IDLE;
         end
         IDLE: begin
            if (axiiv) begin
               state_d    = RECV;
               word_idx_d = IDX_W'(1);
               if (PAYLOAD_IDX == 0) payload_d = axiid;
            end
         end
         RECV: begin
            if (axiiv) begin
               if (word_idx_q == PAY_IDX) payload_d = axiid;
               word_idx_d = word_idx_q + 1'b1;
               if (word_idx_q == MAX_IDX) state_d = OVERLONG;
            end else begin
               state_d = IDLE;
               if (word_idx_q > PAY_IDX && payload_q[15:8] == payload_q[7:0])
                  frame_good = 1'b1;
               else
                  frame_bad = 1'b1;
            end
         end
         OVERLONG: begin
            if (!axiiv) begin
               state_d   = IDLE;
               frame_bad = 1'b1;
            end
         end
         default: state_d = SKIP;
      endcase
   end

   assign wd_inc = wd_q + 23'd1;

   // A good frame takes priority over a watchdog expiry in the same cycle.
   always_comb begin
      buttons_d   = buttons_q;
      valid_d     = 1'b0;
      changed_d   = 1'b0;
      timed_out_d = timed_out_q;
      wd_d        = wd_q;
      good_d      = good_q;
      bad_d       = bad_q;
      if (frame_good) begin
         buttons_d   = payload_q[7:0];
         valid_d     = 1'b1;
         changed_d   = (payload_q[7:0] != buttons_q);
         timed_out_d = 1'b0;
         wd_d        = 23'd0;
         good_d      = sat_inc(good_q);
      end else if (wd_q != WD_LIMIT) begin
         wd_d = wd_inc;
         if (wd_inc == WD_LIMIT) begin
            timed_out_d = 1'b1;
            buttons_d   = 8'd0;
            changed_d   = (buttons_q != 8'd0);
         end
      end
      if (frame_bad) bad_d = sat_inc(bad_q);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= SKIP;
         word_idx_q  <= '0;
         payload_q   <= 16'd0;
         buttons_q   <= 8'd0;
         valid_q     <= 1'b0;
         changed_q   <= 1'b0;
         timed_out_q <= 1'b0;
         good_q      <= 16'd0;
         bad_q       <= 16'd0;
         wd_q        <= 23'd0;
      end else begin
         state_q     <= state_d;
         word_idx_q  <= word_idx_d;
         payload_q   <= payload_d;
         buttons_q   <= buttons_d;
         valid_q     <= valid_d;
         changed_q   <= changed_d;
         timed_out_q <= timed_out_d;
         good_q      <= good_d;
         bad_q       <= bad_d;
         wd_q        <= wd_d;
      end
   end

   assign buttons         = buttons_q;
   assign buttons_valid   = valid_q;
   assign buttons_changed = changed_q;
   assign timed_out       = timed_out_q;
   assign good_count      = good_q;
   assign bad_count       = bad_q;

endmodule

// File: tb/tb_controller_packet_rx.sv
// Bench for controller_packet_rx: directed scenarios plus random frames against a frame-level model.
module tb_controller_packet_rx;

   localparam int PIDX = 12;
   localparam int MAXW = 64;
   localparam int TO   = 100;

   logic        clk = 1'b0;
   logic        rst;
   logic        axiiv;
   logic [15:0] axiid;
   logic [7:0]  buttons;
   logic        buttons_valid;
   logic        buttons_changed;
   logic        timed_out;
   logic [15:0] good_count;
   logic [15:0] bad_count;

   controller_packet_rx #(
      .PAYLOAD_IDX(PIDX),
      .MAX_WORDS(MAXW),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk),
      .rst(rst),
      .axiiv(axiiv),
      .axiid(axiid),
      .buttons(buttons),
      .buttons_valid(buttons_valid),
      .buttons_changed(buttons_changed),
      .timed_out(timed_out),
      .good_count(good_count),
      .bad_count(bad_count)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Pulse monitor, sampled shortly after each active edge.
   int mon_valid = 0;
   int mon_chg   = 0;
   always @(posedge clk) begin
      #2;
      if (buttons_valid === 1'b1) mon_valid <= mon_valid + 1;
      if (buttons_changed === 1'b1) mon_chg <= mon_chg + 1;
   end

   int n_tests = 0;
   int n_fail  = 0;

   // Frame-level model: last accepted button byte, edge of last watchdog clear, counters, pulse totals.
   logic [7:0]  m_btn   = 8'd0;
   int          m_clear = 0;
   int          m_good  = 0;
   int          m_bad   = 0;
   int          m_valid = 0;
   int          m_chg   = 0;
   logic [15:0] fq[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic bit m_timed_out();
      return (cyc - m_clear) >= TO;
   endfunction

   task automatic check_state(input string tag);
      check({tag, "_btn"}, 32'(buttons), m_timed_out() ? 32'd0 : 32'(m_btn));
      check({tag, "_to"}, 32'(timed_out), 32'(m_timed_out()));
      check({tag, "_good"}, 32'(good_count), 32'(m_good));
      check({tag, "_bad"}, 32'(bad_count), 32'(m_bad));
   endtask

   task automatic cycle(input logic v, input logic [15:0] d);
      axiiv = v;
      axiid = d;
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      repeat (n) cycle(1'b0, 16'h0000);
   endtask

   // A watchdog expiry that happened before this clear produced one changed pulse.
   task automatic note_clear(input int edge_no);
      if ((edge_no - m_clear) > TO && m_btn != 8'd0) m_chg++;
      m_clear = edge_no;
   endtask

   task automatic model_reset(input int edge_no);
      note_clear(edge_no);
      m_btn  = 8'd0;
      m_good = 0;
      m_bad  = 0;
   endtask

   task automatic make_frame(input int len, input logic [15:0] pay);
      fq.delete();
      for (int i = 0; i < len; i++) fq.push_back(i == PIDX ? pay : 16'($urandom));
   endtask

   task automatic send_frame(input string tag);
      int          len;
      int          g;
      bit          good;
      bit          exp_chg;
      logic [15:0] pw;
      logic [7:0]  old;
      len = fq.size();
      for (int i = 0; i < len; i++) cycle(1'b1, fq[i]);
      cycle(1'b0, 16'h0000);
      g    = cyc;
      pw   = (len > PIDX) ? fq[PIDX] : 16'h0000;
      good = (len > PIDX) && (len <= MAXW) && (pw[15:8] == pw[7:0]);
      if (good) begin
         old     = ((g - 1 - m_clear) >= TO) ? 8'd0 : m_btn;
         exp_chg = (old != pw[7:0]);
         note_clear(g);
         m_btn  = pw[7:0];
         m_good = (m_good == 65535) ? m_good : m_good + 1;
         m_valid++;
         if (exp_chg) m_chg++;
      end else begin
         exp_chg = ((g - m_clear) == TO) && (m_btn != 8'd0);
         m_bad   = (m_bad == 65535) ? m_bad : m_bad + 1;
      end
      check({tag, "_vld"}, 32'(buttons_valid), 32'(good));
      check({tag, "_chg"}, 32'(buttons_changed), 32'(exp_chg));
      check_state(tag);
   endtask

   initial begin
      int r_edge;
      int len;
      int gap;
      int sel;
      logic [7:0] b;
      logic [15:0] pay;

      // Reset with the link quiet.
      rst   = 1'b1;
      axiiv = 1'b0;
      axiid = 16'h0000;
      idle(3);
      model_reset(cyc);
      rst = 1'b0;
      check("rst_vld", 32'(buttons_valid), 32'd0);
      check("rst_chg", 32'(buttons_changed), 32'd0);
      check_state("rst");

      // First good frame, then pulses drop after one cycle.
      idle(10);
      make_frame(20, 16'h8181);
      send_frame("f1");
      idle(1);
      check("f1_vld_off", 32'(buttons_valid), 32'd0);
      check("f1_chg_off", 32'(buttons_changed), 32'd0);

      // Same payload again: valid but no change.
      make_frame(20, 16'h8181);
      send_frame("f2");

      // Mismatched duplicate byte, then a frame too short to carry the payload.
      make_frame(20, 16'h8180);
      send_frame("bad_dup");
      make_frame(10, 16'h0000);
      send_frame("short");

      // Overlong frame, then a good frame after a single idle cycle.
      make_frame(70, 16'h8181);
      send_frame("overlong");
      make_frame(20, 16'h0303);
      send_frame("after_ol");

      // Frame of exactly the maximum length is judged normally.
      make_frame(MAXW, 16'h1111);
      send_frame("maxlen");

      // Reset during words 5..7 of a frame; the rest must be absorbed.
      make_frame(20, 16'h4242);
      r_edge = 0;
      for (int i = 0; i < 20; i++) begin
         rst = (i >= 5 && i <= 7);
         cycle(1'b1, fq[i]);
         if (i == 7) r_edge = cyc;
      end
      rst = 1'b0;
      model_reset(r_edge);
      cycle(1'b0, 16'h0000);
      check("midrst_vld", 32'(buttons_valid), 32'd0);
      check("midrst_chg", 32'(buttons_changed), 32'd0);
      check_state("midrst");
      make_frame(20, 16'h2424);
      send_frame("post_rst");

      // Watchdog expiry with no traffic.
      make_frame(20, 16'h8181);
      send_frame("pre_to");
      idle(TO - 1);
      check_state("to_edge_m1");
      idle(1);
      check("to_chg", 32'(buttons_changed), 32'(((cyc - m_clear) == TO) && (m_btn != 8'd0)));
      check_state("to_hit");
      idle(1);
      check("to_chg_off", 32'(buttons_changed), 32'd0);
      make_frame(20, 16'h0505);
      send_frame("to_clear");

      // Good frame judged on the exact expiry edge wins.
      idle(79);
      make_frame(20, 16'h0606);
      send_frame("coincide");

      // Random traffic.
      for (int n = 0; n < 30; n++) begin
         gap = ($urandom_range(0, 7) == 0) ? int'($urandom_range(90, 130)) : int'($urandom_range(0, 3));
         idle(gap);
         sel = int'($urandom_range(0, 9));
         if (sel < 2)      len = int'($urandom_range(1, PIDX));
         else if (sel < 8) len = int'($urandom_range(PIDX + 1, MAXW));
         else              len = int'($urandom_range(MAXW + 1, MAXW + 16));
         b   = 8'($urandom_range(0, 255));
         pay = ($urandom_range(0, 9) < 6) ? {b, b} : 16'($urandom);
         make_frame(len, pay);
         send_frame("rnd");
      end

      // Pulse totals over the whole run.
      idle(3);
      if ((cyc - m_clear) >= TO && m_btn != 8'd0) m_chg++;
      check("tot_valid", 32'(mon_valid), 32'(m_valid));
      check("tot_chg", 32'(mon_chg), 32'(m_chg));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/controller_packet_rx.md
# controller_packet_rx

Receive-side decoder for controller button reports: consumes the 16-bit word stream that `network_stack_rx` emits for each accepted UDP frame, extracts the button payload word, and validates its duplicated-byte encoding (`{buttons, buttons}`). It presents a stable 8-bit button state with valid/changed pulses to the console-side logic. It also maintains good/bad frame counters and a link-loss watchdog. Sits directly downstream of `network_stack_rx` on the `eth_refclk` domain.

## Interface

Parameters:
- `PAYLOAD_IDX`, 12, zero-based word index within a frame that carries the button word.
- `MAX_WORDS`, 64, frames longer than this many words are rejected as overlong.
- `TIMEOUT_CYCLES`, 5_000_000, cycles without a good frame before buttons are forced to 0 (100 ms at 50 MHz).

Ports:
- `clk` in 1: `eth_refclk`, 50 MHz. Single clock domain.
- `rst` in 1: synchronous, active-high reset.
- `axiiv` in 1: word valid from `network_stack_rx`. Stays high continuously for the length of a frame.
- `axiid` in 16: word data, sampled when `axiiv` = 1.
- `buttons` out 8: last validated button state.
- `buttons_valid` out 1: one-cycle pulse for each good frame.
- `buttons_changed` out 1: one-cycle pulse when `buttons` takes a new value.
- `timed_out` out 1: level, high while the watchdog has expired.
- `good_count` out 16: good frames, saturating.
- `bad_count` out 16: rejected frames, saturating.

## Operation

- States: SKIP, IDLE, RECV, OVERLONG.
- Reset enters SKIP. SKIP moves to IDLE on the first cycle with `axiiv` = 0. This guarantees a frame already in flight at reset release is discarded whole and not counted.
- IDLE:
  - `axiiv` = 1 → RECV.
  - That word is index 0, and `word_idx` is set to 1.
- RECV, `axiiv` = 1:
  - Capture `axiid` into `payload` when `word_idx` == `PAYLOAD_IDX`.
  - Increment `word_idx`.
  - If the word now arriving is word number `MAX_WORDS` + 1 → OVERLONG.
- RECV, `axiiv` = 0 (frame end), judge the frame:
  - Good frame requires both: `word_idx` > `PAYLOAD_IDX`, and `payload[15:8]` == `payload[7:0]`.
  - Good frame:
    - `buttons` ← `payload[7:0]`.
    - Pulse `buttons_valid`.
    - Pulse `buttons_changed` if the new value ≠ old `buttons`.
    - `good_count` +1.
    - Watchdog ← 0, `timed_out` ← 0.
  - Otherwise: `bad_count` +1, and `buttons` is unchanged.
  - Then → IDLE.
- OVERLONG: ignore data. On `axiiv` = 0, `bad_count` +1 → IDLE.
- Watchdog:
  - A 23-bit counter increments every cycle that no good frame completes.
  - When it reaches `TIMEOUT_CYCLES`:
    - `timed_out` ← 1.
    - `buttons` ← 0.
    - Pulse `buttons_changed` if `buttons` was nonzero.
  - The counter then holds at `TIMEOUT_CYCLES`.
- Counters saturate at 16'hFFFF and never wrap.

## Timing

- All outputs are registered.
- Reset values: `buttons` = 0, `buttons_valid` = 0, `buttons_changed` = 0, `timed_out` = 0, both counters = 0, watchdog = 0.
- Latency: a frame whose last word is at cycle N has `axiiv` = 0 at N+1. `buttons`, `buttons_valid`, `buttons_changed` and counter updates are visible at N+2.
- `buttons_valid` and `buttons_changed` are high for exactly one cycle per event.
- Two frames separated by a single `axiiv`-low cycle are both decoded, with no lost frame.
- A good frame ending in the same cycle the watchdog reaches `TIMEOUT_CYCLES`: the good frame wins. Buttons take the payload, `timed_out` stays 0, and the watchdog resets.
- `rst` asserted mid-frame:
  - All state is cleared at the next edge.
  - The remainder of the frame is absorbed in SKIP.
  - Neither counter changes.
- A frame exactly `MAX_WORDS` long is judged normally.

## Test plan

- Reset, then idle 10 cycles, then a 20-word frame with word 12 = 16'h8181 → `buttons_valid` and `buttons_changed` pulse 2 cycles after the last word. `buttons` = 8'h81, `good_count` = 1.
- Repeat the identical frame → `buttons_valid` pulses, `buttons_changed` does not, `good_count` = 2.
- Frame with word 12 = 16'h8180, then a separate 10-word frame → no pulses, `buttons` stays 8'h81, `bad_count` = 2.
- A 70-word frame with a valid payload, followed after a one-cycle gap by a good frame (payload 16'h0303) → `bad_count` +1, then `buttons` = 8'h03.
- Assert `rst` during word 5 of a frame, release it at word 8 → no counter change, no pulses. The next full good frame decodes normally.
- `TIMEOUT_CYCLES` = 100, `buttons` = 8'h81, no traffic for 100 cycles → `timed_out` = 1, `buttons` = 0, one `buttons_changed` pulse. A good frame then clears `timed_out`.
